// File: rtl/input_buffer.sv
// Two-entry AXI4-Stream skid buffer. The ready, valid and data outputs all come
// from flops, so neither side of the handshake has a combinational path through it.
module input_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                  state;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   main_data;
    logic [DATA_WIDTH-1:0]   skid_data;

    logic in_xfer;
    logic out_xfer;
    logic load_main;
    logic load_skid;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Main loads on first fill, on a simultaneous in/out transfer, or when FULL drains.
    assign load_main = ((state == EMPTY) & in_xfer)
                     | ((state == BUSY) & in_xfer & out_xfer)
                     | ((state == FULL) & out_ready);
    assign load_skid = (state == BUSY) & in_xfer & ~out_xfer;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    // in_ready first rises here, one edge after reset release.
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        state       <= BUSY;
                        out_valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (in_xfer && !out_xfer) begin
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (!in_xfer && out_xfer) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state      <= BUSY;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Data registers carry no reset; out_data is meaningless while out_valid is low.
    always_ff @(posedge aclk) begin
        if (load_main) begin
            main_data <= (state == FULL) ? skid_data : in_data;
        end
        if (load_skid) begin
            skid_data <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data;
    assign level     = state;

endmodule

// File: tb/tb_input_buffer.sv
// Randomized and directed bench for input_buffer, checked against a queue model.
module tb_input_buffer;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    level;

    input_buffer #(.DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    bit            armed = 1'b0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit mdl_ready();
        return armed && (q.size() < 2);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_level"}, DW'(level), DW'(q.size()));
        chk({tag, "_in_ready"}, DW'(in_ready), DW'(mdl_ready()));
        chk({tag, "_out_valid"}, DW'(out_valid), DW'(q.size() > 0));
        if (q.size() > 0) chk({tag, "_out_data"}, out_data, q[0]);
        if (prev_hold) chk({tag, "_stable"}, out_data, prev_data);
    endtask

    // One clock: model transfers decided from pre-edge state, outputs checked after the edge.
    task automatic step(input string tag);
        bit ix;
        bit ox;
        ix = in_valid && mdl_ready();
        ox = (q.size() > 0) && out_ready;
        prev_hold = (q.size() > 0) && !out_ready;
        prev_data = out_data;
        @(posedge aclk);
        if (ox) void'(q.pop_front());
        if (ix) q.push_back(in_data);
        armed = 1'b1;
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input int cycles);
        aresetn = 1'b0;
        #1;
        q.delete();
        armed = 1'b0;
        prev_hold = 1'b0;
        chk("rst_async_level", DW'(level), 0);
        chk("rst_async_in_ready", DW'(in_ready), 0);
        chk("rst_async_out_valid", DW'(out_valid), 0);
        repeat (cycles) @(posedge aclk);
        #1;
        chk("rst_hold_level", DW'(level), 0);
        chk("rst_hold_in_ready", DW'(in_ready), 0);
        chk("rst_hold_out_valid", DW'(out_valid), 0);
        aresetn = 1'b1;
        #1;
        chk("rst_release_in_ready", DW'(in_ready), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] got[$];
        logic [DW-1:0] fill_words[3];
        int accepted;
        int cycles;

        // Reset and start-up
        do_reset(3);
        in_valid = 1'b0;
        step("start");
        chk("start_in_ready", DW'(in_ready), 1);

        // Streaming with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data  = DW'(i);
            in_valid = 1'b1;
            step("stream");
            chk("stream_level_le1", DW'(level <= 2'd1), 1);
            chk("stream_in_ready", DW'(in_ready), 1);
        end
        in_valid = 1'b0;
        repeat (2) step("stream_tail");

        // Backpressure fill
        out_ready = 1'b0;
        fill_words[0] = 32'hA;
        fill_words[1] = 32'hB;
        fill_words[2] = 32'hC;
        in_valid = 1'b1;
        in_data = fill_words[0]; step("fill");
        in_data = fill_words[1]; step("fill");
        in_data = fill_words[2]; step("fill");
        step("fill");
        chk("fill_level", DW'(level), 2);
        chk("fill_in_ready", DW'(in_ready), 0);
        chk("fill_out_data", out_data, 32'hA);

        // Drain with 0xC still offered
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 6; i++) begin
            bit took;
            if (out_valid && out_ready) got.push_back(out_data);
            took = in_valid && in_ready;
            step("drain");
            if (i == 0) chk("drain_in_ready_rise", DW'(in_ready), 1);
            if (took && in_data == 32'hC) in_valid = 1'b0;
        end
        chk("drain_count", DW'(got.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk("drain_order", got[i], fill_words[i]);
            else chk("drain_order_missing", 32'hDEAD_BEEF, fill_words[i]);
        end

        // Random stress
        accepted = 0;
        cycles = 0;
        while (accepted < 10000 && cycles < 60000) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 1) == 1;
            in_data   = $urandom;
            if (in_valid && in_ready) accepted++;
            step("rand");
            cycles++;
        end
        chk("rand_completed", DW'(accepted >= 10000), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step("rand_tail");

        // Reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h11; step("mid");
        in_data = 32'h22; step("mid");
        chk("mid_full_level", DW'(level), 2);
        do_reset(3);
        in_data   = 32'h55;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step("post");
        chk("post_first_edge_no_valid", DW'(out_valid), 0);
        step("post");
        in_valid = 1'b0;
        chk("post_first_valid", DW'(out_valid), 1);
        chk("post_first_word", out_data, 32'h55);
        step("post");
        chk("post_empty", DW'(level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
